// File: rtl/st_byte_packer_pkg.sv
// Shared definitions for the byte packer: frame geometry defaults, word flag layout
// and a constant-friendly clog2.
package st_byte_packer_pkg;
    localparam int FRAME_W         = 320;
    localparam int FRAME_H         = 240;
    localparam int FRAME_BYTES_DEF = FRAME_W * FRAME_H;

    // FIFO entry layout, MSB first: {flags, empty, data}
    localparam int FLAG_W = 2;
    typedef struct packed {
        logic sop;
        logic eop;
    } word_flags_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int p = 1; p < v; p = p * 2) r++;
        return r;
    endfunction
endpackage

// File: rtl/st_byte_packer_if.sv
// Byte-in / word-out streaming bundle. The packer is the slave side; the DMA source
// and the NVMe write path together form the master side.
interface st_byte_packer_if
    import st_byte_packer_pkg::*;
#(
    parameter int WIDTH_MD = 8,
    parameter int LANES    = 4
);
    localparam int EMPTY_W = clog2(LANES);

    logic                      sink_ready;
    logic                      sink_valid;
    logic                      sink_startofpacket;
    logic                      sink_endofpacket;
    logic [WIDTH_MD-1:0]       sink_data;

    logic                      source_ready;
    logic                      source_valid;
    logic                      source_startofpacket;
    logic                      source_endofpacket;
    logic [EMPTY_W-1:0]        source_empty;
    logic [LANES*WIDTH_MD-1:0] source_data;

    modport master (
        output sink_valid, sink_startofpacket, sink_endofpacket, sink_data, source_ready,
        input  sink_ready, source_valid, source_startofpacket, source_endofpacket,
               source_empty, source_data
    );

    modport slave (
        input  sink_valid, sink_startofpacket, sink_endofpacket, sink_data, source_ready,
        output sink_ready, source_valid, source_startofpacket, source_endofpacket,
               source_empty, source_data
    );
endinterface

// File: rtl/st_byte_packer_sync_fifo.sv
// Show-ahead synchronous FIFO: the head entry is presented on dout while not empty.
module sync_fifo
    import st_byte_packer_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = 8
)(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic [W-1:0]            din,
    input  logic                    pop,
    output logic [W-1:0]            dout,
    output logic                    full,
    output logic                    empty,
    output logic [clog2(DEPTH):0]   count
);
    localparam int AW = clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_push, do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/st_byte_packer.sv
// Packs a SOP/EOP framed byte stream little-endian into LANES-byte words, queues
// them in a show-ahead FIFO and keeps a sticky malformed-frame flag.
module st_byte_packer
    import st_byte_packer_pkg::*;
#(
    parameter int WIDTH_MD    = 8,
    parameter int LANES       = 4,
    parameter int FIFO_DEPTH  = 8,
    parameter int FRAME_BYTES = FRAME_BYTES_DEF
)(
    input  logic                 clk,
    input  logic                 rst,
    st_byte_packer_if.slave      bus,
    output logic [15:0]          frame_count,
    output logic                 frame_error
);
    localparam int EMPTY_W = clog2(LANES);
    localparam int DATA_W  = LANES * WIDTH_MD;
    localparam int ENTRY_W = FLAG_W + EMPTY_W + DATA_W;
    localparam int CNT_W   = clog2(FIFO_DEPTH) + 1;
    localparam logic [16:0] FRAME_LEN = 17'(FRAME_BYTES);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_OPEN = 1'b1;

    logic [0:0]         state;
    logic [EMPTY_W-1:0] idx, lane, empty_in;
    logic [DATA_W-1:0]  asm_word, next_word;
    logic [16:0]        byte_cnt, cnt_next;
    logic               sop_seen, accept, restart, drop, word_done;
    word_flags_t        flags_in, flags_out;

    logic [ENTRY_W-1:0] fifo_din, fifo_dout, head;
    logic               fifo_push, fifo_full, fifo_empty;
    logic [CNT_W-1:0]   fifo_count;

    // An SOP always starts a fresh word in lane 0, abandoning any partial word.
    always_comb begin
        accept    = bus.sink_valid & bus.sink_ready;
        restart   = accept & bus.sink_startofpacket;
        drop      = accept & ~bus.sink_startofpacket & (state == ST_IDLE);
        lane      = restart ? '0 : idx;
        next_word = restart ? '0 : asm_word;
        next_word[int'(lane)*WIDTH_MD +: WIDTH_MD] = bus.sink_data;
        cnt_next  = restart ? 17'd1 : ((&byte_cnt) ? byte_cnt : byte_cnt + 17'd1);
        word_done = accept & ~drop &
                    (bus.sink_endofpacket | (lane == EMPTY_W'(LANES - 1)));
        flags_in.sop = restart | sop_seen;
        flags_in.eop = bus.sink_endofpacket;
        empty_in  = bus.sink_endofpacket ? EMPTY_W'(LANES - 1) - lane : '0;
    end

    assign fifo_din  = {flags_in, empty_in, next_word};
    assign fifo_push = word_done & ~fifo_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            idx         <= '0;
            asm_word    <= '0;
            sop_seen    <= 1'b0;
            byte_cnt    <= '0;
            frame_count <= '0;
            frame_error <= 1'b0;
        end else if (drop) begin
            frame_error <= 1'b1;
        end else if (accept) begin
            if (word_done) begin
                asm_word <= '0;
                idx      <= '0;
                sop_seen <= 1'b0;
            end else begin
                asm_word <= next_word;
                idx      <= lane + 1'b1;
                sop_seen <= flags_in.sop;
            end
            if (restart && state == ST_OPEN) frame_error <= 1'b1;
            if (bus.sink_endofpacket) begin
                state       <= ST_IDLE;
                byte_cnt    <= '0;
                frame_count <= frame_count + 16'd1;
                if (cnt_next != FRAME_LEN) frame_error <= 1'b1;
            end else begin
                state    <= ST_OPEN;
                byte_cnt <= cnt_next;
            end
        end
    end

    sync_fifo #(.W(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .din   (fifo_din),
        .pop   (bus.source_ready & ~fifo_empty),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Stale RAM contents are hidden so the outputs read zero while the FIFO is empty.
    assign head = fifo_empty ? '0 : fifo_dout;
    assign {flags_out, bus.source_empty, bus.source_data} = head;
    assign bus.source_startofpacket = flags_out.sop;
    assign bus.source_endofpacket   = flags_out.eop;
    assign bus.source_valid         = ~fifo_empty;
    assign bus.sink_ready           = (fifo_count != CNT_W'(FIFO_DEPTH));
endmodule
